// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multicycle fetch/decode/exec/mem/wb sequencer driving regfile, ALU and data memory
module alu_op_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_rdata_i,
  output logic [3:0]  rf_ra1_o,
  output logic [3:0]  rf_ra2_o,
  input  logic [15:0] rf_rd1_i,
  input  logic [15:0] rf_rd2_i,
  output logic        rf_we_o,
  output logic [3:0]  rf_wa_o,
  output logic [15:0] rf_wd_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [2:0]  alu_control_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic [15:0] dmem_addr_o,
  output logic [15:0] dmem_wdata_o,
  output logic        dmem_we_o,
  output logic        dmem_re_o,
  input  logic [15:0] dmem_rdata_i,
  output logic [15:0] pc_o,
  output logic        halted_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] store_q, store_d;

  logic [3:0]  op, ra, rb, rc;
  logic [15:0] sext_imm, pc_inc, br_target;

  assign op        = ir_q[15:12];
  assign ra        = ir_q[11:8];
  assign rb        = ir_q[7:4];
  assign rc        = ir_q[3:0];
  assign sext_imm  = {{12{rc[3]}}, rc};
  // Branch target has its own adder so the ALU stays free for the compare.
  assign pc_inc    = pc_q + 16'd1;
  assign br_target = pc_inc + sext_imm;

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == S_HALT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      alu_q   <= 16'h0000;
      store_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_d         = alu_q;
    store_d       = store_q;
    rf_ra1_o      = (op == OP_BEQ) ? ra : rb;
    rf_ra2_o      = (op == OP_BEQ) ? rb : ((op == OP_SW) ? ra : rc);
    rf_we_o       = 1'b0;
    rf_wa_o       = ra;
    rf_wd_o       = alu_q;
    alu_a_o       = 16'h0000;
    alu_b_o       = 16'h0000;
    alu_control_o = 3'b000;
    dmem_addr_o   = alu_q;
    dmem_wdata_o  = store_q;
    dmem_we_o     = 1'b0;
    dmem_re_o     = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_rdata_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_result_i;
        case (op)
          OP_ADD, OP_SUB: begin
            alu_a_o       = rf_rd1_i;
            alu_b_o       = rf_rd2_i;
            alu_control_o = (op == OP_SUB) ? 3'b001 : 3'b000;
            state_d       = S_WB;
          end
          OP_ADDI: begin
            alu_a_o = rf_rd1_i;
            alu_b_o = sext_imm;
            state_d = S_WB;
          end
          OP_BEQ: begin
            alu_a_o       = rf_rd1_i;
            alu_b_o       = rf_rd2_i;
            alu_control_o = 3'b001;
            pc_d          = alu_zero_i ? br_target : pc_inc;
            state_d       = S_FETCH;
          end
          OP_LW, OP_SW: begin
            alu_a_o = rf_rd1_i;
            alu_b_o = sext_imm;
            store_d = rf_rd2_i;
            state_d = S_MEM;
          end
          OP_JMP: begin
            pc_d    = {pc_q[15:12], ir_q[11:0]};
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (op == OP_LW) begin
          dmem_re_o = 1'b1;
          state_d   = S_WB;
        end else begin
          dmem_we_o = 1'b1;
          pc_d      = pc_inc;
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        rf_we_o = (ra != 4'd0);
        rf_wd_o = (op == OP_LW) ? dmem_rdata_i : alu_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // An op caught mid-flight by reset must not leave a write behind.
    if (reset_i) begin
      rf_we_o   = 1'b0;
      dmem_we_o = 1'b0;
      dmem_re_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized ISA-level reference check of alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] imem_addr, imem_rdata;
  logic [3:0]  rf_ra1, rf_ra2, rf_wa;
  logic [15:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_re;
  logic [15:0] pc;
  logic        halted;

  always #5 clk = ~clk;

  alu_op_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .rf_ra1_o(rf_ra1), .rf_ra2_o(rf_ra2), .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2),
    .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_control_o(alu_control),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_we_o(dmem_we),
    .dmem_re_o(dmem_re), .dmem_rdata_i(dmem_rdata),
    .pc_o(pc), .halted_o(halted)
  );

  // environment: memories, register file, ALU
  logic [15:0] imem     [0:65535];
  logic [15:0] dmem_env [0:65535];
  bit          dmem_vld [0:65535];
  logic [15:0] rf_env   [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = 4'd0;
  logic [15:0] bd_val = 16'h0000;
  int          st_cnt = 0;

  function automatic logic [15:0] dinit(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  assign rf_rd1     = rf_env[rf_ra1];
  assign rf_rd2     = rf_env[rf_ra2];
  assign alu_result = (alu_control == 3'b001) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zero   = (alu_result == 16'h0000);

  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    if (dmem_re) dmem_rdata <= dmem_vld[dmem_addr] ? dmem_env[dmem_addr] : dinit(dmem_addr);
    if (dmem_we) begin
      dmem_env[dmem_addr] <= dmem_wdata;
      dmem_vld[dmem_addr] <= 1'b1;
      st_cnt <= st_cnt + 1;
    end
    if (rf_we) rf_env[rf_wa] <= rf_wd;
    if (bd_we) rf_env[bd_idx] <= bd_val;
  end

  // architectural reference state
  logic [15:0] regs_m [0:15];
  logic [15:0] dmem_m [0:65535];
  logic [15:0] pc_m;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (pc_m=%h)", tag, got, exp, pc_m);
    end
  endtask

  task automatic begin_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_reset();
    @(negedge clk);
    reset_i = 1'b0;
    pc_m = 16'h0000;
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [15:0] val);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    regs_m[idx] = val;
  endtask

  task automatic run_instr(input logic [15:0] instr);
    logic [3:0]  op, ra, rb, rc;
    logic [15:0] sx, pc1, npc, wd, saddr, sdata, laddr;
    logic [15:0] o_wa, o_wd, o_saddr, o_sdata, o_laddr;
    int ncyc, n_rf, n_st, n_ld, o_rfc;
    bit erf, est, eld, is_halt;
    op = instr[15:12]; ra = instr[11:8]; rb = instr[7:4]; rc = instr[3:0];
    sx = {{12{rc[3]}}, rc};
    pc1 = pc_m + 16'd1;
    ncyc = 3; npc = pc1; erf = 0; est = 0; eld = 0; is_halt = 0;
    wd = 0; saddr = 0; sdata = 0; laddr = 0;
    case (op)
      4'd0: begin ncyc = 4; wd = regs_m[rb] + regs_m[rc]; erf = (ra != 0); end
      4'd1: begin ncyc = 4; wd = regs_m[rb] - regs_m[rc]; erf = (ra != 0); end
      4'd2: begin ncyc = 4; wd = regs_m[rb] + sx;         erf = (ra != 0); end
      4'd3: npc = (regs_m[ra] == regs_m[rb]) ? pc1 + sx : pc1;
      4'd4: begin ncyc = 5; laddr = regs_m[rb] + sx; wd = dmem_m[laddr]; eld = 1; erf = (ra != 0); end
      4'd5: begin ncyc = 4; saddr = regs_m[rb] + sx; sdata = regs_m[ra]; est = 1; end
      4'd6: npc = {pc_m[15:12], instr[11:0]};
      4'd15: begin is_halt = 1; npc = pc_m; end
      default: ;
    endcase

    check_eq("fetch_pc", pc, pc_m);
    check_eq("fetch_imem_addr", imem_addr, pc_m);
    check_eq("halted_running", halted, 0);
    imem[pc_m] = instr;
    n_rf = 0; n_st = 0; n_ld = 0; o_rfc = -1;
    o_wa = 0; o_wd = 0; o_saddr = 0; o_sdata = 0; o_laddr = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rf_we)   begin n_rf++; o_wa = {12'd0, rf_wa}; o_wd = rf_wd; o_rfc = c; end
      if (dmem_we) begin n_st++; o_saddr = dmem_addr; o_sdata = dmem_wdata; end
      if (dmem_re) begin n_ld++; o_laddr = dmem_addr; end
      @(negedge clk);
    end

    check_eq("rf_we_count", n_rf, erf);
    if (erf && n_rf == 1) begin
      check_eq("rf_wa", o_wa, ra);
      check_eq("rf_wd", o_wd, wd);
      check_eq("rf_we_cycle", o_rfc, ncyc - 1);
    end
    check_eq("dmem_we_count", n_st, est);
    if (est && n_st == 1) begin
      check_eq("dmem_st_addr", o_saddr, saddr);
      check_eq("dmem_st_data", o_sdata, sdata);
    end
    check_eq("dmem_re_count", n_ld, eld);
    if (eld && n_ld == 1) check_eq("dmem_ld_addr", o_laddr, laddr);

    if (erf) regs_m[ra] = wd;
    if (est) dmem_m[saddr] = sdata;
    pc_m = npc;

    if (is_halt) begin
      for (int c = 0; c < 20; c++) begin
        check_eq("halt_flag", halted, 1);
        check_eq("halt_pc_frozen", pc, pc_m);
        check_eq("halt_no_strobe", {29'd0, rf_we, dmem_we, dmem_re}, 0);
        @(negedge clk);
      end
      begin_reset();
      end_reset();
    end
  endtask

  task automatic sw_abort(input logic [15:0] instr);
    int st0;
    check_eq("abort_fetch_pc", pc, pc_m);
    imem[pc_m] = instr;
    st0 = st_cnt;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(negedge clk);
    check_eq("abort_dmem_we", dmem_we, 0);
    @(posedge clk);
    #1;
    check_eq("abort_store_count", st_cnt, st0);
    @(negedge clk);
    check_eq("abort_pc_reset", pc, 16'h0000);
    check_eq("abort_imem_addr", imem_addr, 16'h0000);
    reset_i = 1'b0;
    pc_m = 16'h0000;
  endtask

  initial begin
    logic [15:0] instr;
    logic [3:0]  op;
    int r;
    reset_i = 1'b1;
    for (int a = 0; a < 65536; a++) dmem_m[a] = dinit(16'(a));

    // reset with random register contents, then R2=5, R3=7
    begin_reset();
    for (int i = 0; i < 16; i++) set_reg(4'(i), (i == 0) ? 16'h0000 : 16'($urandom));
    set_reg(4'd2, 16'd5);
    set_reg(4'd3, 16'd7);
    end_reset();
    check_eq("rst_imem_addr", imem_addr, 16'h0000);
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_strobes", {29'd0, rf_we, dmem_we, dmem_re}, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_alu_control", alu_control, 3'b000);

    // ADD r1,r2,r3 ; SUB r4,r3,r2
    run_instr(16'h0123);
    run_instr(16'h1432);
    check_eq("t2_pc", pc, 16'd2);
    check_eq("t2_r1", regs_m[1], 16'd12);

    // R1=R2=9, BEQ at pc 10 taken to 9; R2=8, BEQ not taken to 11
    run_instr(16'h2107);
    run_instr(16'h2112);
    run_instr(16'h2207);
    run_instr(16'h2222);
    run_instr(16'h600A);
    run_instr(16'h312E);
    check_eq("beq_taken_pc", pc, 16'd9);
    run_instr(16'h222F);
    run_instr(16'h312E);
    check_eq("beq_not_taken_pc", pc, 16'd11);

    // SW r5,r2,+3 then LW r6,r2,+3 with R2=0x100, R5=0xBEEF
    begin_reset();
    set_reg(4'd2, 16'h0100);
    set_reg(4'd5, 16'hBEEF);
    end_reset();
    run_instr(16'h5523);
    run_instr(16'h4623);
    check_eq("lw_r6", regs_m[6], 16'hBEEF);

    // r0 write suppressed, pc wrap at 0xFFFF, HALT
    run_instr(16'h2005);
    begin_reset();
    end_reset();
    run_instr(16'h300E);
    check_eq("wrap_pre_pc", pc, 16'hFFFF);
    run_instr(16'h7000);
    check_eq("wrap_post_pc", pc, 16'h0000);
    run_instr(16'hF000);

    // reset while the SW is in its memory cycle
    run_instr(16'h2000);
    sw_abort(16'h5523);
    run_instr(16'h7000);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if      (r < 12) op = 4'd0;
      else if (r < 24) op = 4'd1;
      else if (r < 40) op = 4'd2;
      else if (r < 52) op = 4'd3;
      else if (r < 66) op = 4'd4;
      else if (r < 80) op = 4'd5;
      else if (r < 86) op = 4'd6;
      else if (r < 98) op = 4'($urandom_range(7, 14));
      else             op = 4'd15;
      instr = {op, 12'($urandom)};
      run_instr(instr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
